// File: rtl/bus_master_port.sv
// Serial bus master: latches one command, arbitrates for the bus, shifts out a
// {mode, addr} header and either write data (then waits for ack) or reads 8 bits.
module bus_master_port #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        read_en,
    input  logic [7:0]  data_in,
    input  logic [13:0] addr_in,
    input  logic        bus_grant,
    input  logic        bus_in,
    input  logic        bus_in_valid,
    input  logic        slave_ack,
    output logic        bus_request,
    output logic        bus_out,
    output logic        bus_out_valid,
    output logic [7:0]  data_out,
    output logic        done,
    output logic        error
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_WDATA,
        S_WAIT_ACK,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic             enable_prev_q, enable_prev_d;
    logic             mode_q, mode_d;
    logic [13:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rx_q, rx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             bus_request_q, bus_request_d;
    logic             bus_out_q, bus_out_d;
    logic             bus_out_valid_q, bus_out_valid_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             start;
    logic             start_acc;
    logic             tmo_hit;
    logic [7:0]       rx_shift;

    function automatic logic hdr_bit(input logic mode, input logic [13:0] addr,
                                     input logic [3:0] cnt);
        logic [14:0] frame;
        logic [3:0]  idx;
        frame = {mode, addr};
        idx   = 4'd14 - cnt;
        return frame[idx];
    endfunction

    function automatic logic wdata_bit(input logic [7:0] data, input logic [3:0] cnt);
        logic [3:0] idx;
        idx = 4'd7 - cnt;
        return data[idx[2:0]];
    endfunction

    assign start     = enable & ~enable_prev_q;
    assign start_acc = start && (state_q == S_IDLE);
    assign rx_shift  = {rx_q[6:0], bus_in};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; losing the grant mid-frame always wins and re-arbitrates
    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus_grant) state_d = S_HDR;
            end
            S_HDR: begin
                if (!bus_grant)          state_d = S_REQ;
                else if (cnt_q == 4'd14) state_d = mode_q ? S_RDATA : S_WDATA;
            end
            S_WDATA: begin
                if (!bus_grant)         state_d = S_REQ;
                else if (cnt_q == 4'd7) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!bus_grant) begin
                    state_d = S_REQ;
                end else if (slave_ack) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            S_RDATA: begin
                if (!bus_grant) begin
                    state_d = S_REQ;
                end else if (bus_in_valid) begin
                    if (cnt_q == 4'd7) state_d = S_DONE;
                end else if (cnt_q == 4'd0 && tmo_q == TMO_LIMIT) begin
                    // Timeout only guards the first bit; a started byte waits indefinitely
                    state_d = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch, bit/timeout counters and read shift register
    always_comb begin
        enable_prev_d = enable;
        mode_d        = mode_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rx_d          = rx_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;

        if (start_acc) begin
            mode_d  = read_en;
            addr_d  = addr_in;
            wdata_d = data_in;
        end

        if (state_q == S_RDATA && bus_in_valid) begin
            rx_d = rx_shift;
        end

        if (state_d != state_q) begin
            cnt_d = 4'd0;
            tmo_d = '0;
        end else begin
            case (state_q)
                S_HDR, S_WDATA: cnt_d = cnt_q + 4'd1;
                S_RDATA:        cnt_d = bus_in_valid ? cnt_q + 4'd1 : cnt_q;
                default:        cnt_d = cnt_q;
            endcase
            if ((state_q == S_WAIT_ACK || state_q == S_RDATA) && tmo_q != TMO_LIMIT) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Outputs are decoded from the upcoming state so every port is a flop
    always_comb begin
        bus_request_d   = 1'b0;
        bus_out_valid_d = 1'b0;
        bus_out_d       = 1'b0;
        done_d          = 1'b0;
        data_out_d      = data_out_q;
        error_d         = error_q;

        case (state_d)
            S_REQ, S_WAIT_ACK, S_RDATA: begin
                bus_request_d = 1'b1;
            end
            S_HDR: begin
                bus_request_d   = 1'b1;
                bus_out_valid_d = 1'b1;
                bus_out_d       = hdr_bit(mode_q, addr_q, cnt_d);
            end
            S_WDATA: begin
                bus_request_d   = 1'b1;
                bus_out_valid_d = 1'b1;
                bus_out_d       = wdata_bit(wdata_q, cnt_d);
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                bus_request_d = 1'b0;
            end
        endcase

        if (state_q == S_RDATA && state_d == S_DONE && !tmo_hit) begin
            data_out_d = rx_shift;
        end

        if (start_acc) error_d = 1'b0;
        if (tmo_hit)   error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_prev_q   <= 1'b0;
            mode_q          <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rx_q            <= '0;
            cnt_q           <= '0;
            tmo_q           <= '0;
            bus_request_q   <= 1'b0;
            bus_out_q       <= 1'b0;
            bus_out_valid_q <= 1'b0;
            data_out_q      <= '0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            enable_prev_q   <= enable_prev_d;
            mode_q          <= mode_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rx_q            <= rx_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            bus_request_q   <= bus_request_d;
            bus_out_q       <= bus_out_d;
            bus_out_valid_q <= bus_out_valid_d;
            data_out_q      <= data_out_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign bus_request   = bus_request_q;
    assign bus_out       = bus_out_q;
    assign bus_out_valid = bus_out_valid_q;
    assign data_out      = data_out_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: serial bits are checked against a queue
// of expected frame bits filled when each command is issued.
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        read_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [13:0] addr_in = '0;
    logic        bus_grant = 1'b0;
    logic        bus_in = 1'b0;
    logic        bus_in_valid = 1'b0;
    logic        slave_ack = 1'b0;
    logic        bus_request;
    logic        bus_out;
    logic        bus_out_valid;
    logic [7:0]  data_out;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    bus_master_port #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .read_en      (read_en),
        .data_in      (data_in),
        .addr_in      (addr_in),
        .bus_grant    (bus_grant),
        .bus_in       (bus_in),
        .bus_in_valid (bus_in_valid),
        .slave_ack    (slave_ack),
        .bus_request  (bus_request),
        .bus_out      (bus_out),
        .bus_out_valid(bus_out_valid),
        .data_out     (data_out),
        .done         (done),
        .error        (error)
    );

    bit exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int n_pop = 0;
    int done_base;
    int pop_base;
    int guard;
    logic [7:0] rx_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge, serial bits scored
    task automatic tick();
        bit b;
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        if (bus_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bus_out_valid", bus_out_valid, 0);
            end else begin
                b = exp_q.pop_front();
                n_pop++;
                chk("bus_out", bus_out, b);
            end
        end
    endtask

    task automatic push_frame(input logic mode, input logic [13:0] addr,
                              input logic [7:0] data, input logic with_data);
        logic [14:0] hdr;
        hdr = {mode, addr};
        for (int i = 14; i >= 0; i--) exp_q.push_back(hdr[i]);
        if (with_data) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
        end
    endtask

    task automatic issue(input logic rd, input logic [13:0] addr, input logic [7:0] data);
        read_en = rd;
        addr_in = addr;
        data_in = data;
        enable  = 1'b1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            tick();
            g++;
        end
        chk("frame_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_bus_request", bus_request, 0);
        chk("rst_bus_out", bus_out, 0);
        chk("rst_bus_out_valid", bus_out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        // Write 101 to 1001, grant tied high, ack two cycles after the data
        bus_grant = 1'b1;
        done_base = done_cnt;
        push_frame(1'b0, 14'd1001, 8'd101, 1'b1);
        issue(1'b0, 14'd1001, 8'd101);
        tick();
        chk("wr_req_after_edge", bus_request, 1);
        enable = 1'b0;
        drain();
        tick();
        chk("wr_wait_valid_low", bus_out_valid, 0);
        chk("wr_wait_req", bus_request, 1);
        tick();
        tick();
        chk("wr_no_early_done", done, 0);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_error", error, 0);
        chk("wr_req_low_in_done", bus_request, 0);
        tick();
        chk("wr_done_one_cycle", done, 0);
        chk("wr_done_count", done_cnt - done_base, 1);

        // Read 5097, slave returns A5 with gaps in bus_in_valid
        push_frame(1'b1, 14'd5097, 8'd0, 1'b0);
        issue(1'b1, 14'd5097, 8'd0);
        tick();
        enable = 1'b0;
        drain();
        tick();
        chk("rd_valid_low", bus_out_valid, 0);
        rx_byte = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                bus_in_valid = 1'b0;
                tick();
                chk("rd_no_early_done_gap", done, 0);
            end
            bus_in       = rx_byte[7 - i];
            bus_in_valid = 1'b1;
            tick();
            if (i < 7) chk("rd_no_early_done", done, 0);
        end
        bus_in_valid = 1'b0;
        chk("rd_done", done, 1);
        chk("rd_data_out", data_out, 8'hA5);
        chk("rd_error", error, 0);
        chk("rd_req_low", bus_request, 0);
        tick();

        // Enable held three cycles, grant delayed five cycles
        bus_grant = 1'b0;
        done_base = done_cnt;
        push_frame(1'b0, 14'h2A5C, 8'h3C, 1'b1);
        issue(1'b0, 14'h2A5C, 8'h3C);
        tick();
        chk("hold_req_after_edge", bus_request, 1);
        tick();
        tick();
        enable = 1'b0;
        tick();
        tick();
        chk("hold_no_frame_before_grant", bus_out_valid, 0);
        chk("hold_req_waiting", bus_request, 1);
        bus_grant = 1'b1;
        drain();
        tick();
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("hold_done", done, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("hold_no_second_req", bus_request, 0);
        chk("hold_done_count", done_cnt - done_base, 1);

        // Write with no ack: timeout after 16 cycles
        push_frame(1'b0, 14'h3FFF, 8'h81, 1'b1);
        issue(1'b0, 14'h3FFF, 8'h81);
        tick();
        enable = 1'b0;
        drain();
        tick();
        for (int i = 0; i < 16; i++) tick();
        chk("tmo_no_done_at_16", done, 0);
        tick();
        chk("tmo_done_at_17", done, 1);
        chk("tmo_error", error, 1);
        chk("tmo_req_low", bus_request, 0);
        tick();
        chk("tmo_done_pulse", done, 0);
        chk("tmo_error_held", error, 1);

        // Grant dropped mid-header; frame resent in full, one done
        done_base = done_cnt;
        push_frame(1'b0, 14'h1234, 8'hC3, 1'b1);
        issue(1'b0, 14'h1234, 8'hC3);
        tick();
        enable = 1'b0;
        chk("gl_error_cleared_on_start", error, 0);
        pop_base = n_pop;
        guard = 0;
        while (n_pop - pop_base < 6 && guard < 40) begin
            tick();
            guard++;
        end
        chk("gl_six_bits_sent", n_pop - pop_base, 6);
        bus_grant = 1'b0;
        tick();
        chk("gl_valid_dropped", bus_out_valid, 0);
        chk("gl_req_kept", bus_request, 1);
        exp_q.delete();
        push_frame(1'b0, 14'h1234, 8'hC3, 1'b1);
        tick();
        tick();
        chk("gl_waits_for_grant", bus_out_valid, 0);
        bus_grant = 1'b1;
        drain();
        tick();
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("gl_done", done, 1);
        tick();
        chk("gl_done_count", done_cnt - done_base, 1);

        // Reset mid-WDATA, then enable still high after reset starts a clean frame
        done_base = done_cnt;
        push_frame(1'b0, 14'h0F0F, 8'h5A, 1'b1);
        issue(1'b0, 14'h0F0F, 8'h5A);
        tick();
        enable = 1'b0;
        pop_base = n_pop;
        guard = 0;
        while (n_pop - pop_base < 18 && guard < 40) begin
            tick();
            guard++;
        end
        chk("mr_in_wdata", n_pop - pop_base, 18);
        reset = 1'b1;
        tick();
        chk("mr_bus_request", bus_request, 0);
        chk("mr_bus_out", bus_out, 0);
        chk("mr_bus_out_valid", bus_out_valid, 0);
        chk("mr_data_out", data_out, 0);
        chk("mr_done", done, 0);
        chk("mr_error", error, 0);
        exp_q.delete();
        issue(1'b0, 14'h2001, 8'hE7);
        tick();
        reset = 1'b0;
        push_frame(1'b0, 14'h2001, 8'hE7, 1'b1);
        tick();
        chk("mr_new_req", bus_request, 1);
        drain();
        tick();
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("mr_done_clean", done, 1);
        chk("mr_error_clean", error, 0);
        tick();
        chk("mr_done_count", done_cnt - done_base, 1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mr_idle_after", bus_request, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
